// File: rtl/mem_port_arbiter_if.sv
// Bundles the instruction-fetch port, the load/store port and the shared memory
// port of mem_port_arbiter; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_instr_rd_en;
  logic [ADDR_W-1:0] i_instr_addr;
  logic              o_instr_ready;
  logic [DATA_W-1:0] o_instr_data;
  logic              i_data_rd_en;
  logic              i_data_wr_en;
  logic [ADDR_W-1:0] i_data_addr;
  logic [DATA_W-1:0] i_data_wdata;
  logic              o_data_ready;
  logic [DATA_W-1:0] o_data_rdata;
  logic              o_mem_re;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_proto_err;

  modport slave (
    input  i_instr_rd_en, i_instr_addr, i_data_rd_en, i_data_wr_en,
           i_data_addr, i_data_wdata, i_mem_rdata,
    output o_instr_ready, o_instr_data, o_data_ready, o_data_rdata,
           o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_proto_err
  );

  modport master (
    output i_instr_rd_en, i_instr_addr, i_data_rd_en, i_data_wr_en,
           i_data_addr, i_data_wdata, i_mem_rdata,
    input  o_instr_ready, o_instr_data, o_data_ready, o_data_rdata,
           o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata, o_proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between the fetch and load/store
// ports: each grant is IDLE -> ACCESS (strobe) -> RESP (ready pulse), never overlapped.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_port_arbiter_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_data;
  logic              r_grant_data;
  logic              r_op_write;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_instr_ready;
  logic              r_data_ready;
  logic              r_proto_err;

  logic              w_data_req;
  logic              w_grant;
  logic              w_grant_data;
  logic              w_grant_write;
  logic              w_proto_err;

  assign w_data_req = bus.i_data_rd_en | bus.i_data_wr_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and grant decision; requests are only looked at in IDLE
  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_data  = 1'b0;
    w_grant_write = 1'b0;
    w_proto_err   = 1'b0;
    case (r_state)
      IDLE: begin
        w_proto_err = bus.i_data_rd_en & bus.i_data_wr_en;
        if (bus.i_instr_rd_en || w_data_req) begin
          w_grant = 1'b1;
          if (bus.i_instr_rd_en && w_data_req) begin
            w_grant_data = (FIXED_PRIO != 32'sd0) ? 1'b1 : ~r_last_data;
          end else begin
            w_grant_data = w_data_req;
          end
          // rd_en together with wr_en is resolved as a store
          w_grant_write = w_grant_data & bus.i_data_wr_en;
          w_next_state  = ACCESS;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command, response and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data   <= 1'b1;
      r_grant_data  <= 1'b0;
      r_op_write    <= 1'b0;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= {ADDR_W{1'b0}};
      r_mem_wdata   <= {DATA_W{1'b0}};
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_mem_re      <= w_grant & ~w_grant_write;
      r_mem_we      <= w_grant & w_grant_write;
      r_instr_ready <= (r_state == ACCESS) & ~r_grant_data;
      r_data_ready  <= (r_state == ACCESS) & r_grant_data;
      if (w_grant) begin
        r_mem_addr   <= w_grant_data ? bus.i_data_addr : bus.i_instr_addr;
        r_mem_wdata  <= w_grant_data ? bus.i_data_wdata : {DATA_W{1'b0}};
        r_grant_data <= w_grant_data;
        r_op_write   <= w_grant_write;
        r_last_data  <= w_grant_data;
      end else begin
        r_mem_addr   <= r_mem_addr;
        r_mem_wdata  <= r_mem_wdata;
        r_grant_data <= r_grant_data;
        r_op_write   <= r_op_write;
        r_last_data  <= r_last_data;
      end
      if (w_proto_err) begin
        r_proto_err <= 1'b1;
      end else begin
        r_proto_err <= r_proto_err;
      end
    end
  end

  assign bus.o_mem_re      = r_mem_re;
  assign bus.o_mem_we      = r_mem_we;
  assign bus.o_mem_addr    = r_mem_addr;
  assign bus.o_mem_wdata   = r_mem_wdata;
  assign bus.o_instr_ready = r_instr_ready;
  assign bus.o_data_ready  = r_data_ready;
  assign bus.o_proto_err   = r_proto_err;
  // Read data is steered straight from memory during the RESP cycle only
  assign bus.o_instr_data  = r_instr_ready ? bus.i_mem_rdata : {DATA_W{1'b0}};
  assign bus.o_data_rdata  = (r_data_ready && !r_op_write) ? bus.i_mem_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between the RISCV instruction-fetch port and its data (load/store) port.
- Accepts level-held requests from both ports and arbitrates round-robin on conflict (or fixed priority).
- Issues one single-cycle memory command per grant and returns a one-cycle ready pulse with read data.
- Sits between the RISCV core and the memory model, replacing the tie-offs on i_instr_ready and i_data_ready.

Parameters:
- ADDR_W, 32, address width of both requester ports and the memory port.
- DATA_W, 32, data width.
- FIXED_PRIO, 0; 0 = round-robin on conflict, 1 = data port always wins on conflict.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_instr_rd_en  input  1  instruction fetch request, held until o_instr_ready.
- i_instr_addr  input  ADDR_W  fetch address, stable while request held.
- o_instr_ready  output  1  one-cycle completion pulse for the fetch.
- o_instr_data  output  DATA_W  fetch data, valid only while o_instr_ready=1.
- i_data_rd_en  input  1  load request, held until o_data_ready.
- i_data_wr_en  input  1  store request, held until o_data_ready.
- i_data_addr  input  ADDR_W  load/store address.
- i_data_wdata  input  DATA_W  store data.
- o_data_ready  output  1  one-cycle completion pulse for load/store.
- o_data_rdata  output  DATA_W  load data, valid only while o_data_ready=1.
- o_mem_re  output  1  memory read strobe, exactly one cycle per read grant.
- o_mem_we  output  1  memory write strobe, exactly one cycle per write grant.
- o_mem_addr  output  ADDR_W  memory address, registered.
- o_mem_wdata  output  DATA_W  memory write data, registered.
- i_mem_rdata  input  DATA_W  memory read data, valid the cycle after o_mem_re.
- o_proto_err  output  1  sticky: data rd_en and wr_en were sampled high together.

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_grant=DATA.
  - All outputs 0: ready pulses, mem strobes, o_mem_addr, o_mem_wdata, o_*data, o_proto_err.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every granted access takes exactly 3 cycles, with no overlap.
- IDLE, cycle N: sample requests.
  - Data request = i_data_rd_en | i_data_wr_en.
  - If none, stay in IDLE.
  - If one port requests, grant that port.
  - If both request: FIXED_PRIO=1 grants DATA; FIXED_PRIO=0 grants the port not equal to last_grant. After reset, INSTR wins the first tie.
  - On grant: register o_mem_addr and o_mem_wdata from the granted port, register the op, update last_grant, go to ACCESS.
- ACCESS, cycle N+1: exactly one of o_mem_re or o_mem_we is high (registered). Go to RESP.
- RESP, cycle N+2:
  - Ready of the granted port is high for this cycle only.
  - For reads, the port's data output equals i_mem_rdata, muxed combinationally from memory. For writes, data output is 0.
  - The ungranted port's ready stays 0. Go to IDLE.
- Requesters drop or change the request at edge N+3. The arbiter never resamples in ACCESS/RESP, so a held request cannot double-issue.
- A request that arrives in ACCESS/RESP is only seen in the next IDLE.
- Round-robin bound: a continuously held request is granted within 2 arbitrations (worst case 6 cycles).
- Data rd_en and wr_en both high when sampled in IDLE:
  - Treat as a write.
  - Set o_proto_err=1; it stays 1 until reset.
- o_*data outputs read 0 whenever the matching ready is 0.
- Addresses pass unmodified; no alignment checks. Word indexing is the memory's job.
- Reset asserted mid-access (ACCESS or RESP):
  - Immediate return to IDLE with all outputs 0.
  - The pending ready is never issued.
  - A write strobe already presented is not retracted from memory.

Test Plan:
- Single fetch: i_instr_rd_en=1, addr=0x10, memory holds 0x00000013 at 0x10 -> o_mem_re=1 only in cycle N+1 with o_mem_addr=0x10; o_instr_ready=1 in N+2 with o_instr_data=0x00000013; no second o_mem_re while the request is held through N+2.
- Store then load: wr addr=0x40, wdata=0xDEADBEEF -> o_mem_we one cycle, o_data_ready at N+2; then rd addr=0x40 -> o_data_rdata=0xDEADBEEF with o_data_ready.
- Conflict, round-robin (FIXED_PRIO=0), both held from reset -> grant order INSTR, DATA, INSTR, DATA; readies at cycles 2, 5, 8, 11; never both ready in the same cycle.
- Conflict with FIXED_PRIO=1, both held 3 accesses -> data granted every time; instr never ready while data is held.
- Protocol error: i_data_rd_en=i_data_wr_en=1, addr=0x8, wdata=0x5 -> o_mem_we=1, o_mem_re=0, o_proto_err=1 and stays 1 after both drop; cleared only by rst_n=0.
- Reset mid-op: deassert rst_n during ACCESS of a load -> all outputs 0 immediately; after release with no requests, o_data_ready never pulses and state is IDLE (next request completes in 3 cycles).
